uart_io_ctrl: RTL and testbench

- Sits between the CPU execute/special-register path and the byte UART.
- Buffers received bytes, presents the head byte to the CPU as irr/r_data and pops it on the CPU ack.
- Queues CPU write requests (w_req/w_data), reports w_busy, and sequences the UART transmitter one byte at a time with a start/busy handshake.

---
 rtl/uart_io_ctrl.sv | 162 ++++++++++++++++
 tb/tb_uart_io_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_io_ctrl.sv
// CPU <-> byte-UART glue: buffers received bytes for the CPU and queues CPU
// writes, feeding the UART transmitter one byte per start/busy handshake.
module uart_io_ctrl #(
  parameter int RX_DEPTH = 4,
  parameter int TX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_w_req,
  input  logic [7:0] cpu_w_data,
  input  logic       cpu_ack,
  output logic       cpu_w_busy,
  output logic       cpu_irr,
  output logic [7:0] cpu_r_data,
  input  logic       rx_ovf_clr,
  output logic       rx_overrun,
  input  logic       uart_rx_valid,
  input  logic [7:0] uart_rx_data,
  output logic       uart_tx_start,
  output logic [7:0] uart_tx_data,
  input  logic       uart_tx_busy
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL = (RX_AW+1)'(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL = (TX_AW+1)'(TX_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  // ---------------- RX path ----------------
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr, rx_rd_next;
  logic [RX_AW:0]   rx_count, rx_count_next;
  logic             rx_full, rx_empty, rx_push, rx_pop, rx_drop;
  logic [7:0]       rx_head_next;

  assign rx_full  = (rx_count == RX_FULL);
  assign rx_empty = (rx_count == '0);
  assign rx_pop   = cpu_ack && !rx_empty;
  assign rx_push  = uart_rx_valid && (!rx_full || rx_pop);
  assign rx_drop  = uart_rx_valid && rx_full && !rx_pop;

  always_comb begin
    rx_count_next = rx_count;
    unique case ({rx_push, rx_pop})
      2'b10:   rx_count_next = rx_count + 1'b1;
      2'b01:   rx_count_next = rx_count - 1'b1;
      default: rx_count_next = rx_count;
    endcase
  end

  assign rx_rd_next = rx_pop ? rx_rd_ptr + 1'b1 : rx_rd_ptr;

  // The head register is loaded with next cycle's head, so a byte arriving
  // into an empty (or just-emptied) FIFO bypasses the memory.
  always_comb begin
    rx_head_next = 8'h00;
    if (rx_count_next == '0)
      rx_head_next = 8'h00;
    else if (rx_push && (rx_empty || (rx_pop && rx_count == 1)))
      rx_head_next = uart_rx_data;
    else
      rx_head_next = rx_mem[rx_rd_next];
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= uart_rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      rx_count   <= '0;
      cpu_irr    <= 1'b0;
      cpu_r_data <= 8'h00;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      rx_rd_ptr  <= rx_rd_next;
      rx_count   <= rx_count_next;
      cpu_irr    <= (rx_count_next != '0);
      cpu_r_data <= rx_head_next;
      if (rx_drop)
        rx_overrun <= 1'b1;
      else if (rx_ovf_clr)
        rx_overrun <= 1'b0;
    end
  end

  // ---------------- TX path ----------------
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_AW:0]   tx_count, tx_count_next;
  logic             tx_push, tx_pop;
  logic [1:0]       tx_state;

  // cpu_w_busy always equals (tx_count == TX_FULL), so it doubles as the full flag;
  // a write while full is dropped even if a pop happens the same cycle.
  assign tx_push = cpu_w_req && !cpu_w_busy;
  assign tx_pop  = (tx_state == ST_IDLE) && (tx_count != '0) && !uart_tx_busy;

  always_comb begin
    tx_count_next = tx_count;
    unique case ({tx_push, tx_pop})
      2'b10:   tx_count_next = tx_count + 1'b1;
      2'b01:   tx_count_next = tx_count - 1'b1;
      default: tx_count_next = tx_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= cpu_w_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr  <= '0;
      tx_rd_ptr  <= '0;
      tx_count   <= '0;
      cpu_w_busy <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      tx_count   <= tx_count_next;
      cpu_w_busy <= (tx_count_next == TX_FULL);
    end
  end

  // GAP masks the UART's one-cycle delay between start and busy rising.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state      <= ST_IDLE;
      uart_tx_start <= 1'b0;
      uart_tx_data  <= 8'h00;
    end else begin
      unique case (tx_state)
        ST_IDLE: begin
          if (tx_pop) begin
            uart_tx_data  <= tx_mem[tx_rd_ptr];
            uart_tx_start <= 1'b1;
            tx_state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          uart_tx_start <= 1'b0;
          tx_state      <= ST_GAP;
        end
        ST_GAP: tx_state <= ST_WAIT;
        ST_WAIT: begin
          if (!uart_tx_busy) tx_state <= ST_IDLE;
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Directed bench for uart_io_ctrl: expected bytes are queued at stimulus time
// and popped by monitors on CPU acks and UART start pulses.
module tb_uart_io_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cpu_w_req = 1'b0;
  logic [7:0] cpu_w_data = 8'h00;
  logic       cpu_ack = 1'b0;
  logic       cpu_w_busy;
  logic       cpu_irr;
  logic [7:0] cpu_r_data;
  logic       rx_ovf_clr = 1'b0;
  logic       rx_overrun;
  logic       uart_rx_valid = 1'b0;
  logic [7:0] uart_rx_data = 8'h00;
  logic       uart_tx_start;
  logic [7:0] uart_tx_data;
  logic       uart_tx_busy;

  logic [7:0] rx_exp_q[$];
  logic [7:0] tx_exp_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_count = 0;
  int last_start = -100;
  int busy_len = 10;
  logic hold_busy = 1'b0;
  logic [7:0] busy_cnt;

  uart_io_ctrl #(.RX_DEPTH(4), .TX_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_w_req(cpu_w_req), .cpu_w_data(cpu_w_data), .cpu_ack(cpu_ack),
    .cpu_w_busy(cpu_w_busy), .cpu_irr(cpu_irr), .cpu_r_data(cpu_r_data),
    .rx_ovf_clr(rx_ovf_clr), .rx_overrun(rx_overrun),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
    .uart_tx_start(uart_tx_start), .uart_tx_data(uart_tx_data),
    .uart_tx_busy(uart_tx_busy)
  );

  // ---------------- clock / reset / UART model ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cnt <= 8'h00;
    else if (uart_tx_start) busy_cnt <= 8'(busy_len);
    else if (busy_cnt != 8'h00) busy_cnt <= busy_cnt - 8'h01;
  end
  assign uart_tx_busy = hold_busy | (busy_cnt != 8'h00);

  // ---------------- checks ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " w_busy"},   {7'd0, cpu_w_busy},    8'h00);
    check({tag, " irr"},      {7'd0, cpu_irr},       8'h00);
    check({tag, " r_data"},   cpu_r_data,            8'h00);
    check({tag, " overrun"},  {7'd0, rx_overrun},    8'h00);
    check({tag, " tx_start"}, {7'd0, uart_tx_start}, 8'h00);
    check({tag, " tx_data"},  uart_tx_data,          8'h00);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cpu_ack === 1'b1 && cpu_irr === 1'b1) begin
      tests++;
      if (rx_exp_q.size() == 0) begin
        fails++;
        $display("FAIL rx_read: actual=%h expected=<none> (t=%0t)", cpu_r_data, $time);
      end else begin
        logic [7:0] e;
        e = rx_exp_q.pop_front();
        if (cpu_r_data !== e) begin
          fails++;
          $display("FAIL rx_read: actual=%h expected=%h (t=%0t)", cpu_r_data, e, $time);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && uart_tx_start === 1'b1) begin
      start_count++;
      tests++;
      if (tx_exp_q.size() == 0) begin
        fails++;
        $display("FAIL tx_start: actual=%h expected=<no start> (t=%0t)", uart_tx_data, $time);
      end else begin
        logic [7:0] e;
        e = tx_exp_q.pop_front();
        if (uart_tx_data !== e) begin
          fails++;
          $display("FAIL tx_data: actual=%h expected=%h (t=%0t)", uart_tx_data, e, $time);
        end
      end
      tests++;
      if (cyc - last_start < 4) begin
        fails++;
        $display("FAIL tx_spacing: actual=%0d expected>=4 (t=%0t)", cyc - last_start, $time);
      end
      last_start = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_push(input logic [7:0] d);
    uart_rx_valid = 1'b1;
    uart_rx_data  = d;
    tick();
    uart_rx_valid = 1'b0;
  endtask

  task automatic ack();
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
  endtask

  task automatic clr_ovf();
    rx_ovf_clr = 1'b1;
    tick();
    rx_ovf_clr = 1'b0;
  endtask

  task automatic tx_write(input logic [7:0] d);
    cpu_w_req  = 1'b1;
    cpu_w_data = d;
    tick();
    cpu_w_req  = 1'b0;
  endtask

  task automatic wait_tx_drain(input int max_cycles);
    int n = 0;
    while (tx_exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check_int("tx_drain_pending", tx_exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int starts_before;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // RX single byte, ack three edges later
    rx_push(8'h41);
    rx_exp_q.push_back(8'h41);
    #3;
    check("rx1 irr", {7'd0, cpu_irr}, 8'h01);
    check("rx1 r_data", cpu_r_data, 8'h41);
    tick();
    tick();
    ack();
    #3;
    check("rx1 irr after ack", {7'd0, cpu_irr}, 8'h00);
    check("rx1 r_data after ack", cpu_r_data, 8'h00);

    // RX overrun: fifth byte dropped
    for (int i = 0; i < 5; i++) begin
      rx_push(8'h10 + 8'(i));
      if (i < 4) rx_exp_q.push_back(8'h10 + 8'(i));
      if (i == 3) begin
        #3;
        check("ovf before drop", {7'd0, rx_overrun}, 8'h00);
      end
    end
    #3;
    check("ovf set", {7'd0, rx_overrun}, 8'h01);
    check("ovf head", cpu_r_data, 8'h10);
    repeat (4) ack();
    #3;
    check("ovf drained irr", {7'd0, cpu_irr}, 8'h00);
    clr_ovf();
    #3;
    check("ovf cleared", {7'd0, rx_overrun}, 8'h00);

    // Overrun coincident with clear: set wins
    for (int i = 0; i < 4; i++) begin
      rx_push(8'h60 + 8'(i));
      rx_exp_q.push_back(8'h60 + 8'(i));
    end
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'h99;
    rx_ovf_clr    = 1'b1;
    tick();
    uart_rx_valid = 1'b0;
    rx_ovf_clr    = 1'b0;
    #3;
    check("ovf set beats clr", {7'd0, rx_overrun}, 8'h01);
    repeat (4) ack();
    clr_ovf();

    // Full FIFO: push and ack in the same cycle
    for (int i = 0; i < 4; i++) begin
      rx_push(8'h10 + 8'(i));
      rx_exp_q.push_back(8'h10 + 8'(i));
    end
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'h20;
    cpu_ack       = 1'b1;
    rx_exp_q.push_back(8'h20);
    tick();
    uart_rx_valid = 1'b0;
    cpu_ack       = 1'b0;
    #3;
    check("full push+ack no ovf", {7'd0, rx_overrun}, 8'h00);
    check("full push+ack head", cpu_r_data, 8'h11);
    repeat (4) ack();
    #3;
    check("full push+ack drained", {7'd0, cpu_irr}, 8'h00);

    // Empty FIFO: ack ignored, push with ack kept
    ack();
    #3;
    check("ack empty irr", {7'd0, cpu_irr}, 8'h00);
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'h33;
    cpu_ack       = 1'b1;
    rx_exp_q.push_back(8'h33);
    tick();
    uart_rx_valid = 1'b0;
    cpu_ack       = 1'b0;
    #3;
    check("empty push+ack irr", {7'd0, cpu_irr}, 8'h01);
    check("empty push+ack data", cpu_r_data, 8'h33);
    ack();
    #3;
    check_int("rx queue consumed", rx_exp_q.size(), 0);

    // TX single: start during t+1..t+2
    busy_len = 10;
    tx_exp_q.push_back(8'h55);
    tx_write(8'h55);
    #3;
    check("tx1 no start at t", {7'd0, uart_tx_start}, 8'h00);
    tick();
    #3;
    check("tx1 start at t+1", {7'd0, uart_tx_start}, 8'h01);
    check("tx1 data", uart_tx_data, 8'h55);
    tick();
    #3;
    check("tx1 start one cycle", {7'd0, uart_tx_start}, 8'h00);
    repeat (15) tick();
    check_int("tx1 start count", start_count, 1);

    // TX full/drop with transmitter held busy
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cpu_w_req  = 1'b1;
      cpu_w_data = 8'hA0 + 8'(i);
      if (i < 4) tx_exp_q.push_back(8'hA0 + 8'(i));
      tick();
      if (i == 2) begin
        #3;
        check("w_busy after 3 writes", {7'd0, cpu_w_busy}, 8'h00);
      end
      if (i == 3) begin
        #3;
        check("w_busy after 4 writes", {7'd0, cpu_w_busy}, 8'h01);
      end
    end
    cpu_w_req = 1'b0;
    #3;
    check("w_busy after dropped write", {7'd0, cpu_w_busy}, 8'h01);
    hold_busy = 1'b0;
    tick();
    #3;
    check("w_busy after first pop", {7'd0, cpu_w_busy}, 8'h00);
    wait_tx_drain(200);
    repeat (20) tick();
    check_int("tx full start count", start_count, 5);

    // Fast UART: starts land exactly at the minimum spacing
    busy_len = 1;
    for (int i = 0; i < 3; i++) begin
      tx_exp_q.push_back(8'hD0 + 8'(i));
      tx_write(8'hD0 + 8'(i));
    end
    wait_tx_drain(100);
    repeat (10) tick();

    // Reset during WAIT with two bytes queued
    busy_len = 20;
    starts_before = start_count;
    tx_exp_q.push_back(8'hB0);
    tx_write(8'hB0);
    tx_write(8'hB1);
    tx_write(8'hB2);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (30) tick();
    check_int("no start after reset", start_count, starts_before + 1);
    check_int("reset tx queue", tx_exp_q.size(), 0);
    check("post reset w_busy", {7'd0, cpu_w_busy}, 8'h00);

    // Normal operation after reset
    busy_len = 10;
    tx_exp_q.push_back(8'hC3);
    tx_write(8'hC3);
    wait_tx_drain(50);
    repeat (15) tick();
    check_int("final start count", start_count, starts_before + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
